if_fetch_queue: RTL and testbench



---
 rtl/if_fetch_queue.sv | 140 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: issues sequential fetches into a prefetch FIFO and hands
// instructions to ID over valid/ready; EX redirects discard queued and in-flight work.
module if_fetch_queue #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h100
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [ILEN-1:0] i_imem_rdata,
  input  logic            i_branch_in_ex,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic            i_jump_in_ex,
  input  logic [XLEN-1:0] i_jump_target,
  input  logic            i_ex_flush_if,
  input  logic            i_id_ready,
  output logic            o_if_valid,
  output logic [ILEN-1:0] o_if_instr,
  output logic [XLEN-1:0] o_if_pc,
  output logic            o_if_misalign
);

  localparam int unsigned     PW        = $clog2(FQ_DEPTH);
  localparam logic [PW+1:0]   DEPTH_SUM = (PW+2)'(FQ_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] deliver_pc;
  logic [XLEN-1:0] q_pc    [FQ_DEPTH];
  logic [ILEN-1:0] q_instr [FQ_DEPTH];
  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;
  logic [XLEN-1:0] sh_pc   [FQ_DEPTH];
  logic [PW:0]     sh_wr;
  logic [PW:0]     sh_rd;
  logic [PW:0]     outstanding;
  logic [PW:0]     drop;

  logic [PW:0]     count;
  logic [PW+1:0]   reserved;
  logic [PW:0]     outstanding_next;
  logic            grant;
  logic            push;
  logic            pop;
  logic            redirect;
  logic            misaligned;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] head_next_pc;

  always_comb begin
    count       = wr_ptr - rd_ptr;
    // Space is reserved for every in-flight request, so a response can always be pushed.
    reserved    = {1'b0, count} + {1'b0, outstanding};
    o_imem_req  = (state == RUN) && (reserved < DEPTH_SUM);
    o_imem_addr = fetch_pc;
    o_if_valid  = (count != '0);
    o_if_instr  = q_instr[rd_ptr[PW-1:0]];
    o_if_pc     = q_pc[rd_ptr[PW-1:0]];

    grant        = o_imem_req && i_imem_gnt;
    push         = i_imem_rvalid && (drop == '0);
    pop          = o_if_valid && i_id_ready;
    head_next_pc = o_if_pc + PC_STEP;
    outstanding_next = outstanding + {{PW{1'b0}}, grant} - {{PW{1'b0}}, i_imem_rvalid};

    redirect = i_branch_in_ex || i_jump_in_ex || i_ex_flush_if;
    if (i_branch_in_ex)    target = i_branch_target;
    else if (i_jump_in_ex) target = i_jump_target;
    else if (pop)          target = head_next_pc;
    else                   target = deliver_pc;
    misaligned = (target[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      fetch_pc      <= RESET_PC;
      deliver_pc    <= RESET_PC;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      sh_wr         <= '0;
      sh_rd         <= '0;
      outstanding   <= '0;
      drop          <= '0;
      o_if_misalign <= 1'b0;
      for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
        sh_pc[i]   <= '0;
      end
    end else begin
      o_if_misalign <= 1'b0;
      outstanding   <= outstanding_next;
      if (state == BOOT) state <= RUN;

      if (grant) begin
        sh_pc[sh_wr[PW-1:0]] <= fetch_pc;
        sh_wr                <= sh_wr + 1'b1;
        fetch_pc             <= fetch_pc + PC_STEP;
      end
      if (i_imem_rvalid) begin
        sh_rd <= sh_rd + 1'b1;
        if (drop != '0) drop <= drop - 1'b1;
      end
      if (push) begin
        q_pc[wr_ptr[PW-1:0]]    <= sh_pc[sh_rd[PW-1:0]];
        q_instr[wr_ptr[PW-1:0]] <= i_imem_rdata;
        wr_ptr                  <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        deliver_pc <= head_next_pc;
      end

      // Redirect overrides the updates above; its drop count includes this cycle's grant.
      if (redirect) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        drop       <= outstanding_next;
        deliver_pc <= target;
        if (misaligned) begin
          o_if_misalign <= 1'b1;
          state         <= HALT;
        end else begin
          fetch_pc <= target;
          state    <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: in-order memory model with programmable latency,
// grant/delivery logs sampled on the falling edge, hand-computed expectations.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        o_imem_req;
  logic [63:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata  = '0;
  logic        i_branch_in_ex;
  logic [63:0] i_branch_target;
  logic        i_jump_in_ex;
  logic [63:0] i_jump_target;
  logic        i_ex_flush_if;
  logic        i_id_ready;
  logic        o_if_valid;
  logic [31:0] o_if_instr;
  logic [63:0] o_if_pc;
  logic        o_if_misalign;

  int n_vec = 0;
  int n_bad = 0;
  int lat   = 1;
  int ecount = 0;
  int gsz;

  logic [63:0] pend_addr [$];
  int          pend_due  [$];
  logic [63:0] g_addr [$];
  logic [63:0] g_edge [$];
  logic [63:0] d_pc   [$];
  logic [63:0] d_ins  [$];
  logic [63:0] d_edge [$];

  if_fetch_queue #(
    .XLEN    (64),
    .ILEN    (32),
    .FQ_DEPTH(4),
    .RESET_PC(64'h100)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .o_imem_req     (o_imem_req),
    .o_imem_addr    (o_imem_addr),
    .i_imem_gnt     (i_imem_gnt),
    .i_imem_rvalid  (i_imem_rvalid),
    .i_imem_rdata   (i_imem_rdata),
    .i_branch_in_ex (i_branch_in_ex),
    .i_branch_target(i_branch_target),
    .i_jump_in_ex   (i_jump_in_ex),
    .i_jump_target  (i_jump_target),
    .i_ex_flush_if  (i_ex_flush_if),
    .i_id_ready     (i_id_ready),
    .o_if_valid     (o_if_valid),
    .o_if_instr     (o_if_instr),
    .o_if_pc        (o_if_pc),
    .o_if_misalign  (o_if_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return {4'hA, a[27:0]};
  endfunction

  function automatic logic [63:0] qget(input logic [63:0] q[$], input int i);
    return (q.size() > i) ? q[i] : '1;
  endfunction

  // Memory responder and logs; everything seen here is stable until the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = '0;
    end else begin
      if (pend_due.size() != 0 && pend_due[0] <= ecount + 1) begin
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = instr_of(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        i_imem_rvalid = 1'b0;
      end
      if (o_imem_req && i_imem_gnt) begin
        pend_addr.push_back(o_imem_addr);
        pend_due.push_back(ecount + 1 + lat);
        g_addr.push_back(o_imem_addr);
        g_edge.push_back(64'(ecount + 1));
      end
      if (o_if_valid && i_id_ready) begin
        d_pc.push_back(o_if_pc);
        d_ins.push_back({32'b0, o_if_instr});
        d_edge.push_back(64'(ecount + 1));
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    g_addr.delete(); g_edge.delete();
    d_pc.delete(); d_ins.delete(); d_edge.delete();
  endtask

  task automatic release_reset();
    tick();
    tick();
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    release_reset();
  endtask

  initial begin
    rst_n = 1'b1;
    i_imem_gnt = 1'b1;
    i_branch_in_ex = 1'b0; i_branch_target = '0;
    i_jump_in_ex = 1'b0;   i_jump_target = '0;
    i_ex_flush_if = 1'b0;
    i_id_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_req",      o_imem_req,    0);
    check("rst_addr",     o_imem_addr,   64'h100);
    check("rst_valid",    o_if_valid,    0);
    check("rst_instr",    o_if_instr,    0);
    check("rst_pc",       o_if_pc,       0);
    check("rst_misalign", o_if_misalign, 0);

    // Reset boot, latency 1, ID always ready
    release_reset();
    check("boot_noreq", o_imem_req, 0);
    tick();
    check("first_req",  o_imem_req, 1);
    check("first_addr", o_imem_addr, 64'h100);
    repeat (8) tick();
    check("boot_g0", qget(g_addr, 0), 64'h100);
    check("boot_g1", qget(g_addr, 1), 64'h104);
    check("boot_g2", qget(g_addr, 2), 64'h108);
    check("boot_gap01", qget(g_edge, 1) - qget(g_edge, 0), 1);
    check("boot_gap12", qget(g_edge, 2) - qget(g_edge, 1), 1);
    check("boot_d0pc",  qget(d_pc, 0),  64'h100);
    check("boot_d0ins", qget(d_ins, 0), 64'hA000_0100);
    check("boot_d1pc",  qget(d_pc, 1),  64'h104);
    check("boot_d1ins", qget(d_ins, 1), 64'hA000_0104);
    check("boot_dgap",  qget(d_edge, 1) - qget(d_edge, 0), 1);

    // Backpressure, latency 3
    i_id_ready = 1'b0;
    lat = 3;
    do_reset();
    repeat (12) tick();
    check("bp_grants", 64'(g_addr.size()), 4);
    check("bp_req",    o_imem_req, 0);
    check("bp_valid",  o_if_valid, 1);
    check("bp_headpc", o_if_pc, 64'h100);
    d_pc.delete(); d_ins.delete(); d_edge.delete();
    i_id_ready = 1'b1;
    tick();
    check("bp_reissue_req",  o_imem_req, 1);
    check("bp_reissue_addr", o_imem_addr, 64'h110);
    repeat (3) tick();
    check("bp_d0", qget(d_pc, 0), 64'h100);
    check("bp_d1", qget(d_pc, 1), 64'h104);
    check("bp_d2", qget(d_pc, 2), 64'h108);
    check("bp_d3", qget(d_pc, 3), 64'h10C);
    check("bp_d3ins", qget(d_ins, 3), 64'hA000_010C);
    check("bp_g4", qget(g_addr, 4), 64'h110);

    // Branch + jump together with three responses in flight
    lat = 3;
    do_reset();
    repeat (4) tick();
    i_branch_in_ex = 1'b1; i_branch_target = 64'h200;
    i_jump_in_ex   = 1'b1; i_jump_target   = 64'h300;
    tick();
    i_branch_in_ex = 1'b0; i_jump_in_ex = 1'b0;
    check("br_valid", o_if_valid, 0);
    check("br_req",   o_imem_req, 1);
    check("br_addr",  o_imem_addr, 64'h200);
    repeat (12) tick();
    check("br_d0pc",  qget(d_pc, 0),  64'h200);
    check("br_d0ins", qget(d_ins, 0), 64'hA000_0200);
    check("br_d1pc",  qget(d_pc, 1),  64'h204);
    check("br_g3",    qget(g_addr, 3), 64'h10C);
    check("br_g4",    qget(g_addr, 4), 64'h200);
    gsz = 0;
    foreach (g_addr[i]) if (g_addr[i] == 64'h300) gsz++;
    check("br_no300", 64'(gsz), 0);

    // Flush replays from the oldest undelivered PC
    lat = 1;
    i_id_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    check("fl_full_pc", o_if_pc, 64'h100);
    i_id_ready = 1'b1;
    tick();
    tick();
    i_id_ready = 1'b0;
    i_ex_flush_if = 1'b1;
    tick();
    i_ex_flush_if = 1'b0;
    check("fl_valid", o_if_valid, 0);
    check("fl_addr",  o_imem_addr, 64'h108);
    check("fl_ndel",  64'(d_pc.size()), 2);
    check("fl_pre0",  qget(d_pc, 0), 64'h100);
    check("fl_pre1",  qget(d_pc, 1), 64'h104);
    d_pc.delete(); d_ins.delete(); d_edge.delete();
    i_id_ready = 1'b1;
    repeat (8) tick();
    check("fl_d0pc",  qget(d_pc, 0),  64'h108);
    check("fl_d0ins", qget(d_ins, 0), 64'hA000_0108);
    check("fl_d1pc",  qget(d_pc, 1),  64'h10C);

    // Misaligned jump halts fetch; an aligned branch resumes it
    lat = 1;
    do_reset();
    repeat (6) tick();
    i_jump_in_ex = 1'b1; i_jump_target = 64'h202;
    tick();
    i_jump_in_ex = 1'b0;
    check("ma_pulse", o_if_misalign, 1);
    check("ma_req",   o_imem_req, 0);
    check("ma_valid", o_if_valid, 0);
    gsz = g_addr.size();
    tick();
    check("ma_pulse_end", o_if_misalign, 0);
    repeat (6) tick();
    check("ma_nogrant", 64'(g_addr.size()), 64'(gsz));
    check("ma_drained", o_if_valid, 0);
    i_branch_in_ex = 1'b1; i_branch_target = 64'h400;
    tick();
    i_branch_in_ex = 1'b0;
    check("ma_res_mis",  o_if_misalign, 0);
    check("ma_res_req",  o_imem_req, 1);
    check("ma_res_addr", o_imem_addr, 64'h400);
    d_pc.delete(); d_ins.delete(); d_edge.delete();
    repeat (6) tick();
    check("ma_g_res", qget(g_addr, gsz), 64'h400);
    check("ma_d0pc",  qget(d_pc, 0),  64'h400);
    check("ma_d0ins", qget(d_ins, 0), 64'hA000_0400);

    // Asynchronous reset with a full FIFO
    lat = 1;
    i_id_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    check("ar_full", o_if_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    check("ar_valid", o_if_valid, 0);
    check("ar_req",   o_imem_req, 0);
    check("ar_addr",  o_imem_addr, 64'h100);
    check("ar_pc",    o_if_pc, 0);
    i_id_ready = 1'b1;
    release_reset();
    repeat (8) tick();
    check("ar_g0", qget(g_addr, 0), 64'h100);
    check("ar_d0", qget(d_pc, 0),  64'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
